// File: rtl/hex_display_pkg.sv
// Shared definitions for the multiplexed hex display path: defaults,
// scan-state encodings and the nibble-select helper.
package hex_display_pkg;

   localparam int DEFAULT_DIGITS = 4;
   localparam int MAX_DIGITS     = 16;

   typedef enum logic {
      GUARD = 1'b0,
      SHOW  = 1'b1
   } scan_state_e;

   // Nibble k of a word; callers zero-extend narrower words to MAX_DIGITS nibbles.
   function automatic logic [3:0] nibble_sel(input logic [4*MAX_DIGITS-1:0] word,
                                             input logic [3:0]              k);
      nibble_sel = 4'(word >> {k, 2'b00});
   endfunction

endpackage

// File: rtl/hex_scan_timer.sv
// Slot counter for the display scan: GUARD/SHOW phase, digit index and
// slot/frame end strobes, plus the next-cycle phase and index.
module hex_scan_timer
   import hex_display_pkg::*;
#(
   parameter  int DIGITS       = DEFAULT_DIGITS,
   parameter  int PRESCALE     = 50000,
   parameter  int BLANK_CYCLES = 2,
   localparam int IW           = $clog2(DIGITS),
   localparam int CW           = $clog2(PRESCALE)
) (
   input  logic          clk,
   input  logic          reset,
   output logic          in_guard,
   output logic          slot_end,
   output logic          frame_end,
   output logic          show_next,
   output logic [IW-1:0] idx,
   output logic [IW-1:0] idx_next
);

   scan_state_e   state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [IW-1:0] idx_r, idx_s;

   assign slot_end  = (cnt_r == CW'(PRESCALE - 1));
   assign frame_end = slot_end && (idx_r == IW'(DIGITS - 1));
   assign in_guard  = (state_r == GUARD);
   assign show_next = (state_s == SHOW);
   assign idx       = idx_r;
   assign idx_next  = idx_s;

   // Next-state logic: guard phase, then show phase until the slot wraps.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r + CW'(1);
      idx_s   = idx_r;
      case (state_r)
         GUARD: begin
            if (cnt_r == CW'(BLANK_CYCLES - 1)) begin
               state_s = SHOW;
            end else begin
               state_s = GUARD;
            end
         end
         SHOW: begin
            if (slot_end) begin
               state_s = GUARD;
               cnt_s   = {CW{1'b0}};
               idx_s   = (idx_r == IW'(DIGITS - 1)) ? {IW{1'b0}} : idx_r + IW'(1);
            end else begin
               state_s = SHOW;
            end
         end
         default: begin
            state_s = GUARD;
            cnt_s   = {CW{1'b0}};
            idx_s   = {IW{1'b0}};
         end
      endcase
   end

   // Scan state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= GUARD;
         cnt_r   <= {CW{1'b0}};
         idx_r   <= {IW{1'b0}};
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         idx_r   <= idx_s;
      end
   end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexes a DIGITS-nibble word onto a shared seven-segment bus with
// double-buffered loads, guard blanking and registered anode/value outputs.
module hex_scan_driver
   import hex_display_pkg::*;
#(
   parameter  int DIGITS       = DEFAULT_DIGITS,
   parameter  int PRESCALE     = 50000,
   parameter  int BLANK_CYCLES = 2,
   localparam int IW           = $clog2(DIGITS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [4*DIGITS-1:0] load_data,
   input  logic [DIGITS-1:0]   blank_mask,
   output logic [3:0]          digit_value,
   output logic [DIGITS-1:0]   digit_sel,
   output logic                frame_done
);

   logic                in_guard_s, slot_end_s, frame_end_s, show_next_s;
   logic [IW-1:0]       idx_s, idx_next_s;

   logic [4*DIGITS-1:0] active_r, active_s;
   logic [4*DIGITS-1:0] pending_r, pending_s;
   logic                pend_full_r, pend_full_s;
   logic                accept_s;
   logic                load_ready_r, frame_done_r;
   logic [DIGITS-1:0]   digit_sel_r, sel_s;
   logic [3:0]          digit_value_r, value_s;

   hex_scan_timer #(
      .DIGITS       (DIGITS),
      .PRESCALE     (PRESCALE),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .in_guard  (in_guard_s),
      .slot_end  (slot_end_s),
      .frame_end (frame_end_s),
      .show_next (show_next_s),
      .idx       (idx_s),
      .idx_next  (idx_next_s)
   );

   // Buffer update: pending moves to active only at a frame boundary, so a frame never mixes words.
   always_comb begin
      accept_s    = load_valid && !pend_full_r;
      active_s    = active_r;
      pending_s   = pending_r;
      pend_full_s = pend_full_r;
      if (frame_end_s) begin
         if (pend_full_r) begin
            active_s    = pending_r;
            pend_full_s = 1'b0;
         end else if (accept_s) begin
            active_s    = load_data;
         end else begin
            active_s    = active_r;
         end
      end else if (accept_s) begin
         pending_s   = load_data;
         pend_full_s = 1'b1;
      end else begin
         pend_full_s = pend_full_r;
      end
   end

   // Output next values, computed from the timer's next phase so registers line up with the slot.
   always_comb begin
      sel_s   = {DIGITS{1'b1}};
      value_s = digit_value_r;
      if (show_next_s && !blank_mask[idx_next_s]) begin
         sel_s[idx_next_s] = 1'b0;
      end else begin
         sel_s = {DIGITS{1'b1}};
      end
      if (slot_end_s) begin
         value_s = nibble_sel((4*MAX_DIGITS)'(active_s), 4'(idx_next_s));
      end else begin
         value_s = digit_value_r;
      end
   end

   // Buffer, handshake and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         active_r      <= {(4*DIGITS){1'b0}};
         pending_r     <= {(4*DIGITS){1'b0}};
         pend_full_r   <= 1'b0;
         load_ready_r  <= 1'b1;
         frame_done_r  <= 1'b0;
         digit_sel_r   <= {DIGITS{1'b1}};
         digit_value_r <= 4'h0;
      end else begin
         active_r      <= active_s;
         pending_r     <= pending_s;
         pend_full_r   <= pend_full_s;
         load_ready_r  <= ~pend_full_s;
         frame_done_r  <= frame_end_s;
         digit_sel_r   <= sel_s;
         digit_value_r <= value_s;
      end
   end

   assign load_ready  = load_ready_r;
   assign frame_done  = frame_done_r;
   assign digit_sel   = digit_sel_r;
   assign digit_value = digit_value_r;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Self-checking bench for hex_scan_driver (DIGITS=4, PRESCALE=8, BLANK_CYCLES=2)
// with a load scoreboard and a per-cycle slot-position reference.
module tb_hex_scan_driver;

   localparam int DIGITS   = 4;
   localparam int PRESCALE = 8;
   localparam int BLANK    = 2;
   localparam int FRAME    = DIGITS * PRESCALE;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_valid = 1'b0;
   logic [15:0] load_data = 16'h0000;
   logic [3:0]  blank_mask = 4'h0;
   logic        load_ready;
   logic [3:0]  digit_value;
   logic [3:0]  digit_sel;
   logic        frame_done;

   int          check_cnt = 0;
   int          error_cnt = 0;
   int          t = 0;
   logic [15:0] act_m = 16'h0000;
   logic [15:0] exp_q[$];
   logic        fd_m = 1'b0;
   logic        acc_m = 1'b0;

   hex_scan_driver #(
      .DIGITS       (DIGITS),
      .PRESCALE     (PRESCALE),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_data   (load_data),
      .blank_mask  (blank_mask),
      .digit_value (digit_value),
      .digit_sel   (digit_sel),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      if (obs !== exp) begin
         error_cnt++;
         if (error_cnt <= 20)
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", tag, obs, exp, t);
      end
   endtask

   // One clock: update the reference on the rising edge, compare on the falling edge.
   task automatic tick();
      int         pos;
      int         slot;
      logic [3:0] es;
      @(posedge clk);
      fd_m  = 1'b0;
      acc_m = 1'b0;
      if (reset) begin
         t     = 0;
         exp_q.delete();
         act_m = 16'h0000;
      end else begin
         if (load_valid && exp_q.size() == 0) begin
            exp_q.push_back(load_data);
            acc_m = 1'b1;
         end
         if (t % FRAME == FRAME - 1) begin
            fd_m = 1'b1;
            if (exp_q.size() > 0) act_m = exp_q.pop_front();
         end
         t++;
      end
      @(negedge clk);
      pos  = t % PRESCALE;
      slot = (t / PRESCALE) % DIGITS;
      es   = 4'hF;
      if (pos >= BLANK && !blank_mask[slot]) es[slot] = 1'b0;
      check_value("digit_sel",   32'(digit_sel),   32'(es));
      check_value("digit_value", 32'(digit_value), 32'((act_m >> (4 * slot)) & 16'h000F));
      check_value("load_ready",  32'(load_ready),  32'(exp_q.size() == 0));
      check_value("frame_done",  32'(frame_done),  32'(fd_m));
      check_value("one_anode",   32'($countones(~digit_sel) <= 1), 32'(1));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic run_until(input int phase);
      int k = 0;
      while ((t % FRAME) != phase && k < 4 * FRAME) begin
         tick();
         k++;
      end
   endtask

   task automatic load_word(input logic [15:0] w);
      int k = 0;
      load_valid = 1'b1;
      load_data  = w;
      do begin
         tick();
         k++;
      end while (!acc_m && k < 4 * FRAME);
      load_valid = 1'b0;
      load_data  = 16'h0000;
      check_value("load_accept", 32'(acc_m), 32'(1));
   endtask

   initial begin
      run(3);
      reset = 1'b0;
      // Load in the first cycle, then free-run three frames.
      load_word(16'h1234);
      run(3 * FRAME);
      // Two loads mid-frame: the second waits for the boundary.
      run_until(10);
      load_word(16'hAAAA);
      load_word(16'h5555);
      run(2 * FRAME);
      // Handshake coincident with the frame boundary and an empty pending buffer.
      run_until(FRAME - 1);
      load_word(16'h9C3E);
      run(FRAME + 4);
      // Blanked digits keep their timing.
      blank_mask = 4'b0101;
      run(2 * FRAME);
      blank_mask = 4'b0000;
      run(4);
      // Reset in SHOW of digit 2 with a word pending.
      run_until(5);
      load_word(16'h7E81);
      run_until(20);
      reset = 1'b1;
      run(2);
      reset = 1'b0;
      run(2 * FRAME);
      $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
